// File: rtl/wf8_pkg.sv
// Shared constants and fetch-state encoding for the WF8 8-bit core.
package wf8_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INSN_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/insn_fetch_pc_reg.sv
// Program counter: synchronous reset, redirect load and wrapping increment.
module pc_reg #(
    parameter int unsigned W = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] pc
);

    // Load wins over increment; the increment wraps modulo 2^W.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + W'(1);
        end
    end

endmodule

// File: rtl/insn_fetch.sv
// WF8 instruction fetch: owns the PC, talks to instruction memory and holds
// one fetched instruction for the decoder; redirects drain stale responses.
module insn_fetch
    import wf8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] insn_out,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_valid,
    input  logic              insn_ready,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_e      state_q, state_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_d;
    logic [INSN_W-1:0] out_d;
    logic [ADDR_W-1:0] ipc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (redirect_pc),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            insn_valid <= 1'b0;
            insn_out   <= '0;
            insn_pc    <= '0;
        end else begin
            state_q    <= state_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            insn_valid <= valid_d;
            insn_out   <= out_d;
            insn_pc    <= ipc_d;
        end
    end

    // Redirect takes priority in every state; the request address only moves
    // once the outstanding request has completed.
    always_comb begin
        state_d = state_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        valid_d = insn_valid;
        out_d   = insn_out;
        ipc_d   = insn_pc;
        pc_load = 1'b0;
        pc_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_en) begin
                    pc_load = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_en) begin
                    pc_load = 1'b1;
                    if (imem_valid) begin
                        addr_d = redirect_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_valid) begin
                    out_d   = imem_rdata;
                    ipc_d   = imem_addr;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    pc_inc  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    state_d = S_REQ;
                end else if (insn_ready) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                pc_load = redirect_en;
                if (imem_valid) begin
                    addr_d  = redirect_en ? redirect_pc : pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: directed scenarios plus a randomized
// run checked against an in-order PC/instruction stream model.
module tb_insn_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic [7:0] insn_out;
    logic [7:0] insn_pc;
    logic       insn_valid;
    logic       insn_ready = 1'b0;
    logic       redirect_en = 1'b0;
    logic [7:0] redirect_pc = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    int  mem_cnt = 0;
    int  mem_lat = 1;
    int  lat_fixed = 1;
    bit  force_valid = 1'b0;
    bit  last_resp = 1'b0;

    always #5 clk = ~clk;

    insn_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .insn_out    (insn_out),
        .insn_pc     (insn_pc),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
    );

    task automatic set_lat(input int l);
        lat_fixed = l;
        mem_lat   = (l != 0) ? l : int'($urandom_range(1, 4));
    endtask

    // One clock: drive inputs at negedge, memory answers in the lat-th cycle
    // of a request, then return 1 time unit after the rising edge.
    task automatic step(input logic rdy, input logic ren, input logic [7:0] rpc, input logic rst_v);
        @(negedge clk);
        rst         = rst_v;
        insn_ready  = rdy;
        redirect_en = ren;
        redirect_pc = rpc;
        last_resp   = 1'b0;
        if (force_valid) begin
            imem_valid = 1'b1;
            imem_rdata = 8'h5A;
        end else if (!rst_v && imem_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr];
                last_resp  = 1'b1;
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 8'($urandom);
            end
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (rst_v || last_resp) begin
            mem_cnt = 0;
            mem_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 8'h00 || insn_valid !== 1'b0 ||
            insn_out !== 8'h00 || insn_pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b out=%h pc=%h required 0 0 0 00 00",
                     imem_req, imem_addr, insn_valid, insn_out, insn_pc);
        end
    endtask

    task automatic test_sequential();
        int cap_cycle [2];
        int n;
        set_lat(1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL seq_first_req: req=%b addr=%h required 1 00", imem_req, imem_addr);
        end
        n = 0;
        for (int c = 0; c < 12 && n < 2; c++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            if (insn_valid === 1'b1) begin
                cap_cycle[n] = c;
                checks++;
                if (insn_pc !== 8'(n) || insn_out !== ((n == 0) ? 8'hA1 : 8'hB2)) begin
                    errors++;
                    $display("FAIL seq_capture%0d: out=%h pc=%h required %h %h", n, insn_out, insn_pc,
                             (n == 0) ? 8'hA1 : 8'hB2, 8'(n));
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL seq_count: captured=%0d required 2", n);
        end else begin
            checks++;
            if (cap_cycle[1] - cap_cycle[0] != 2) begin
                errors++;
                $display("FAIL seq_throughput: spacing=%0d required 2", cap_cycle[1] - cap_cycle[0]);
            end
        end
    endtask

    task automatic test_latency_stall();
        set_lat(3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || insn_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat_req_stable: req=%b addr=%h valid=%b required 1 00 0",
                         imem_req, imem_addr, insn_valid);
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (insn_valid !== 1'b1 || insn_out !== 8'hA1 || insn_pc !== 8'h00 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL lat_hold: valid=%b out=%h pc=%h req=%b required 1 a1 00 0",
                         insn_valid, insn_out, insn_pc, imem_req);
            end
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h01 || insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_next_req: req=%b addr=%h valid=%b required 1 01 0", imem_req, imem_addr, insn_valid);
        end
    endtask

    task automatic test_redirect_drain();
        bit got;
        set_lat(3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h05, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
            errors++;
            $display("FAIL drain_idle_redirect: req=%b addr=%h required 1 05", imem_req, imem_addr);
        end
        step(1'b0, 1'b1, 8'h40, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h05 || insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold_old: req=%b addr=%h valid=%b required 1 05 0", imem_req, imem_addr, insn_valid);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h40 || insn_valid !== 1'b0 || insn_out === 8'hFF) begin
            errors++;
            $display("FAIL drain_discard: req=%b addr=%h valid=%b out=%h required 1 40 0 not-ff",
                     imem_req, imem_addr, insn_valid, insn_out);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            got = (insn_valid === 1'b1);
        end
        checks++;
        if (!got || insn_pc !== 8'h40 || insn_out !== 8'h3C) begin
            errors++;
            $display("FAIL drain_capture: valid=%b out=%h pc=%h required 1 3c 40", insn_valid, insn_out, insn_pc);
        end
    endtask

    task automatic test_redirect_hold();
        bit got;
        set_lat(1);
        step(1'b1, 1'b1, 8'h10, 1'b0);
        checks++;
        if (insn_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
            errors++;
            $display("FAIL hold_redirect: valid=%b req=%b addr=%h required 0 1 10", insn_valid, imem_req, imem_addr);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            got = (insn_valid === 1'b1);
        end
        checks++;
        if (!got || insn_pc !== 8'h10 || insn_out !== 8'h77) begin
            errors++;
            $display("FAIL hold_capture: valid=%b out=%h pc=%h required 1 77 10", insn_valid, insn_out, insn_pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        int n;
        set_lat(1);
        step(1'b1, 1'b1, 8'hFE, 1'b0);
        exp_pc = 8'hFE;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (insn_valid === 1'b1) begin
                checks++;
                if (insn_pc !== exp_pc || insn_out !== mem[exp_pc]) begin
                    errors++;
                    $display("FAIL wrap_pc%0d: out=%h pc=%h required %h %h", n, insn_out, insn_pc, mem[exp_pc], exp_pc);
                end
                exp_pc = exp_pc + 8'd1;
                n++;
            end
            step(1'b1, 1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wrap_count: captured=%0d required 3", n);
        end
    endtask

    task automatic test_reset_drain();
        bit got;
        set_lat(4);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 8'h00 || insn_valid !== 1'b0 ||
            insn_out !== 8'h00 || insn_pc !== 8'h00) begin
            errors++;
            $display("FAIL rstdrain_outputs: req=%b addr=%h valid=%b out=%h pc=%h required 0 00 0 00 00",
                     imem_req, imem_addr, insn_valid, insn_out, insn_pc);
        end
        force_valid = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        force_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00 || insn_valid !== 1'b0 || insn_out !== 8'h00) begin
            errors++;
            $display("FAIL rstdrain_stray: req=%b addr=%h valid=%b out=%h required 1 00 0 00",
                     imem_req, imem_addr, insn_valid, insn_out);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            got = (insn_valid === 1'b1);
        end
        checks++;
        if (!got || insn_pc !== 8'h00 || insn_out !== 8'hA1) begin
            errors++;
            $display("FAIL rstdrain_capture: valid=%b out=%h pc=%h required 1 a1 00", insn_valid, insn_out, insn_pc);
        end
    endtask

    // Model: delivered instructions are mem[p], mem[p+1], ... restarting at
    // the target after every redirect; a same-cycle redirect cancels a hand-off.
    task automatic test_random();
        logic [7:0] exp_pc, rpc, p_addr, p_out, p_pc;
        logic       rdy, ren, p_req, p_iv;
        int         idle;
        set_lat(0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        exp_pc = 8'h00;
        idle   = 0;
        for (int c = 0; c < 1500; c++) begin
            rdy    = ($urandom_range(0, 9) < 6);
            ren    = ($urandom_range(0, 99) < 7);
            rpc    = 8'($urandom);
            p_req  = imem_req;
            p_addr = imem_addr;
            p_iv   = insn_valid;
            p_out  = insn_out;
            p_pc   = insn_pc;
            if (p_iv && rdy && !ren) begin
                checks++;
                if (insn_pc !== exp_pc || insn_out !== mem[exp_pc]) begin
                    errors++;
                    $display("FAIL rand_deliver: out=%h pc=%h required %h %h", insn_out, insn_pc, mem[exp_pc], exp_pc);
                end
                exp_pc = exp_pc + 8'd1;
                idle = 0;
            end
            if (ren) begin
                exp_pc = rpc;
                idle = 0;
            end
            step(rdy, ren, rpc, 1'b0);
            idle++;
            if (p_req && !last_resp) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    errors++;
                    $display("FAIL rand_req_stable: req=%b addr=%h required 1 %h", imem_req, imem_addr, p_addr);
                end
            end
            if (p_iv && !rdy && !ren) begin
                checks++;
                if (insn_valid !== 1'b1 || insn_out !== p_out || insn_pc !== p_pc) begin
                    errors++;
                    $display("FAIL rand_hold: valid=%b out=%h pc=%h required 1 %h %h",
                             insn_valid, insn_out, insn_pc, p_out, p_pc);
                end
            end
            if (idle > 60) begin
                errors++;
                $display("FAIL rand_progress: idle_cycles=%0d required <=60", idle);
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA1;
        mem[8'h01] = 8'hB2;
        mem[8'h05] = 8'hFF;
        mem[8'h10] = 8'h77;
        mem[8'h40] = 8'h3C;
        test_reset();
        test_sequential();
        test_latency_stall();
        test_redirect_drain();
        test_redirect_hold();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
